pwm_duty_ramp: RTL and testbench
================================

// Module: pwm_duty_ramp
// PURPOSE
//  Slew-rate limiter feeding pwm_out: accepts a target duty from control logic and
//  walks the duty toward it by STEP once every PERIOD_TICKS pwm_clk rising edges.
//  Drives pwm_out.duty/update directly; update pulses only when duty changes, at most
//  once per step interval. Prevents full-scale duty jumps on the PWM output.
// PARAMETERS
//  STEP          1    duty increment/decrement per step event; legal range 1..255
//  PERIOD_TICKS  256  pwm_clk rising edges per step event; legal range 1..65535
// PORTS
//  clk           in   1   system clock; all logic on rising edge
//  nRst          in   1   asynchronous active-low reset
//  pwm_clk       in   1   PWM tick clock, asynchronous to clk, slower than clk/4
//  target        in   8   requested duty, sampled when load=1
//  load          in   1   one-cycle strobe: latch target; may be held/repeated
//  duty          out  8   current duty to pwm_out.duty
//  update        out  1   one-cycle strobe to pwm_out.update
//  busy          out  1   1 while duty != latched target
// BEHAVIOUR
//  Reset (async, nRst=0): duty=0, update=0, busy=0, target_q=0, tick_cnt=0,
//   sync flops=0, pend=0, state=IDLE. Takes effect immediately, even mid-ramp.
//  Tick: pwm_clk through 2-flop synchroniser; rising edge of sync output gives tick,
//   high for exactly 1 clk, 3 clk edges after the pwm_clk rise (max).
//  tick_cnt (16b): on tick, ==PERIOD_TICKS-1 -> 0 and step event fires; else +1.
//   Free-running in both states; not reset by load.
//  load: target_q<=target on the same edge. Latest load wins. A load on the same edge
//   as a step event: the step uses the OLD target_q; the new value is used from the next
//   step. state/busy follow the comparison duty!=target_q, evaluated every cycle.
//  States: IDLE (duty==target_q, busy=0) and RAMP (duty!=target_q, busy=1).
//   IDLE->RAMP on the edge after target_q differs; RAMP->IDLE when duty reaches target_q.
//  Step event in RAMP: diff = {1'b0,target_q} - {1'b0,duty} (9b signed).
//   |diff| <= STEP -> duty<=target_q; diff>0 -> duty+=STEP; diff<0 -> duty-=STEP.
//   Never wraps: result is always between the old duty and target_q inclusive.
//   Step event in IDLE: no change and no update.
//  Direction reversal: a load during RAMP moves the next step toward the new target_q.
//   If the new target_q equals the current duty, go IDLE and issue no update.
//  update timing: duty changes on edge N; pend set at N; update=1 for the cycle after
//   edge N+1 only. duty is stable for >=1 clk before and during update. Back-to-back
//   steps (PERIOD_TICKS=1) still give separate 1-cycle pulses.
//  No update at reset release or while duty is unchanged.
// TESTING
//  1 Reset: drive nRst=0 with pwm_clk running -> duty=0, update=0, busy=0. Release:
//    no update for 1000 clk.
//  2 Ramp up, STEP=1, PERIOD_TICKS=4: load target=3 -> busy=1; duty goes 1,2,3, one
//    step per 4 pwm_clk rises, exactly 3 update pulses; then busy=0.
//  3 Clamp, STEP=16: duty=250, load 255 -> one step to 255 (no wrap to 10).
//    Then load 0 -> 239,223,...,15, then 0; busy falls with the last step.
//  4 Reversal: ramping 0->200 at duty=50, load 20 -> the next steps decrease toward
//    20. Load==duty mid-ramp -> busy=0 next cycle, no update.
//  5 Collision: load on the same edge as a step event -> that step uses the old target;
//    check duty/update against the model. Checker: duty is constant across each
//    update-high cycle and the cycle before it.
//  6 Reset mid-ramp: nRst=0 during a pending update -> update never asserts, all
//    outputs 0 asynchronously. After release, tick_cnt restarts at 0.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter for the PWM duty: walks duty toward a latched target
// by STEP once every PERIOD_TICKS rising edges of the asynchronous pwm_clk.
module pwm_duty_ramp #(
    parameter int STEP         = 1,
    parameter int PERIOD_TICKS = 256
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       pwm_clk,
    input  logic [7:0] target,
    input  logic       load,
    output logic [7:0] duty,
    output logic       update,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    localparam logic [7:0]  STEP_B = 8'(STEP);
    localparam logic [15:0] LAST   = 16'(PERIOD_TICKS - 1);

    state_t      state;
    state_t      state_n;
    logic        sync1;
    logic        sync2;
    logic        sync2_d;
    logic        tick;
    logic        step_ev;
    logic [15:0] tick_cnt;
    logic [7:0]  target_q;
    logic [7:0]  duty_n;
    logic        pend;
    logic [8:0]  diff;
    logic [8:0]  mag;
    logic        near;
    logic        up;
    logic        dn;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= pwm_clk;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign tick    = sync2 & ~sync2_d;
    assign step_ev = tick && (tick_cnt == LAST);

    // Free-running; a load never realigns the step grid.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            target_q <= '0;
        end else if (load) begin
            target_q <= target;
        end
    end

    always_comb begin
        diff    = {1'b0, target_q} - {1'b0, duty};
        mag     = diff[8] ? (~diff + 9'd1) : diff;
        near    = (mag <= {1'b0, STEP_B});
        up      = !near && !diff[8];
        dn      = !near && diff[8];
        duty_n  = duty;
        state_n = (duty != target_q) ? RAMP : IDLE;
        if (step_ev && state == RAMP) begin
            unique case (1'b1)
                near:    duty_n = target_q;
                up:      duty_n = duty + STEP_B;
                dn:      duty_n = duty - STEP_B;
                default: duty_n = duty;
            endcase
        end
    end

    // update trails the duty change by one cycle so duty is settled first.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            duty   <= '0;
            pend   <= 1'b0;
            update <= 1'b0;
        end else begin
            state  <= state_n;
            duty   <= duty_n;
            pend   <= (duty_n != duty);
            update <= pend;
        end
    end

    assign busy = (state == RAMP);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Randomised bench for pwm_duty_ramp: two instances (fine and coarse step)
// share stimulus and are compared each cycle against an event-level model.
module tb_pwm_duty_ramp;

    localparam int SA = 1;
    localparam int PA = 4;
    localparam int SB = 16;
    localparam int PB = 3;

    logic       clk = 1'b0;
    logic       nRst;
    logic       pwm_clk = 1'b0;
    logic [7:0] target;
    logic       load;
    logic [7:0] duty_a;
    logic [7:0] duty_b;
    logic       update_a;
    logic       update_b;
    logic       busy_a;
    logic       busy_b;

    pwm_duty_ramp #(.STEP(SA), .PERIOD_TICKS(PA)) dut_a (
        .clk(clk), .nRst(nRst), .pwm_clk(pwm_clk), .target(target),
        .load(load), .duty(duty_a), .update(update_a), .busy(busy_a)
    );

    pwm_duty_ramp #(.STEP(SB), .PERIOD_TICKS(PB)) dut_b (
        .clk(clk), .nRst(nRst), .pwm_clk(pwm_clk), .target(target),
        .load(load), .duty(duty_b), .update(update_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    int step_sz[2] = '{SA, SB};
    int per[2]     = '{PA, PB};

    logic [7:0] d_o[2];
    logic       u_o[2];
    logic       b_o[2];
    assign d_o[0] = duty_a;
    assign d_o[1] = duty_b;
    assign u_o[0] = update_a;
    assign u_o[1] = update_b;
    assign b_o[0] = busy_a;
    assign b_o[1] = busy_b;

    // reference model state
    int m_duty[2] = '{0, 0};
    int m_tq[2]   = '{0, 0};
    int due[2]    = '{-1, -1};
    int upd_at[2] = '{-1, -1};
    bit m_busy[2] = '{0, 0};
    int ecnt      = 0;
    int rises     = 0;
    bit was_busy;
    int nd;

    logic [7:0] prev_d[2];
    logic       prev_u[2] = '{1'b0, 1'b0};
    logic [7:0] seq0[$];
    logic [7:0] seq1[$];

    function automatic int toward(int d, int t, int s);
        if (t - d <= s && d - t <= s) return t;
        if (t > d) return d + s;
        return d - s;
    endfunction

    always #5 clk = ~clk;

    logic [2:0] pdiv = 3'd0;
    always @(negedge clk) begin
        pdiv    = pdiv + 3'd1;
        pwm_clk = pdiv[2];
    end

    // A pwm_clk rise becomes a step three clk edges later.
    always @(posedge pwm_clk) begin
        if (nRst === 1'b1) begin
            rises++;
            for (int i = 0; i < 2; i++)
                if (rises % per[i] == 0) due[i] = ecnt + 3;
        end
    end

    always @(negedge nRst) begin
        rises = 0;
        for (int i = 0; i < 2; i++) begin
            m_duty[i] = 0;
            m_tq[i]   = 0;
            m_busy[i] = 1'b0;
            due[i]    = -1;
            upd_at[i] = -1;
        end
    end

    always @(posedge clk) begin
        ecnt++;
        if (nRst === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                was_busy  = m_busy[i];
                m_busy[i] = (m_duty[i] != m_tq[i]);
                if (due[i] == ecnt && was_busy) begin
                    nd = toward(m_duty[i], m_tq[i], step_sz[i]);
                    if (nd != m_duty[i]) begin
                        m_duty[i] = nd;
                        upd_at[i] = ecnt + 1;
                    end
                end
                if (load === 1'b1) m_tq[i] = int'(target);
            end
        end
    end

    // Cycle-by-cycle scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic exp_u;
            exp_u = (nRst === 1'b1) && (ecnt == upd_at[i]);
            checks += 3;
            if (d_o[i] !== 8'(m_duty[i])) begin
                errors++;
                $display("FAIL duty inst%0d t=%0t got %0d want %0d", i, $time, d_o[i], m_duty[i]);
            end
            if (u_o[i] !== exp_u) begin
                errors++;
                $display("FAIL update inst%0d t=%0t got %0b want %0b", i, $time, u_o[i], exp_u);
            end
            if (b_o[i] !== m_busy[i]) begin
                errors++;
                $display("FAIL busy inst%0d t=%0t got %0b want %0b", i, $time, b_o[i], m_busy[i]);
            end
            if (u_o[i] === 1'b1) begin
                checks++;
                if (d_o[i] !== prev_d[i]) begin
                    errors++;
                    $display("FAIL stable_pre inst%0d got %0d want %0d", i, d_o[i], prev_d[i]);
                end
            end
            if (prev_u[i] === 1'b1 && nRst === 1'b1) begin
                checks++;
                if (d_o[i] !== prev_d[i]) begin
                    errors++;
                    $display("FAIL stable_post inst%0d got %0d want %0d", i, d_o[i], prev_d[i]);
                end
            end
            prev_d[i] = d_o[i];
            prev_u[i] = (nRst === 1'b1) ? u_o[i] : 1'b0;
        end
        if (update_a === 1'b1) seq0.push_back(duty_a);
        if (update_b === 1'b1) seq1.push_back(duty_b);
    end

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        target = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        while (!(m_duty[0] == m_tq[0] && m_duty[1] == m_tq[1] &&
                 !m_busy[0] && !m_busy[1] &&
                 ecnt > upd_at[0] && ecnt > upd_at[1])) begin
            @(negedge clk);
            n++;
            if (n >= budget) begin
                to = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge pwm_clk);
        #2 nRst = 1'b1;
    endtask

    task automatic test_reset();
        int nu;
        nRst   = 1'b0;
        load   = 1'b0;
        target = 8'd0;
        repeat (20) @(negedge clk);
        checks++;
        if ({duty_a, duty_b, update_a, update_b, busy_a, busy_b} !== 20'd0) begin
            errors++;
            $display("FAIL reset_vals got %h/%h u%b%b b%b%b want 0", duty_a, duty_b,
                     update_a, update_b, busy_a, busy_b);
        end
        release_reset();
        nu = 0;
        repeat (1000) begin
            @(negedge clk);
            if (update_a === 1'b1 || update_b === 1'b1) nu++;
        end
        checks++;
        if (nu != 0) begin
            errors++;
            $display("FAIL reset_release_updates got %0d want 0", nu);
        end
    endtask

    task automatic test_ramp_up();
        bit to;
        seq0.delete();
        seq1.delete();
        do_load(8'd3);
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL ramp_busy got %b%b want 11", busy_a, busy_b);
        end
        wait_idle(2000, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL ramp_timeout got timeout want idle");
        end
        checks++;
        if (seq0.size() != 3) begin
            errors++;
            $display("FAIL ramp_a_count got %0d want 3", seq0.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seq0[k] !== 8'(k + 1)) begin
                    errors++;
                    $display("FAIL ramp_a_seq[%0d] got %0d want %0d", k, seq0[k], k + 1);
                end
            end
        end
        checks++;
        if (seq1.size() != 1 || duty_b !== 8'd3) begin
            errors++;
            $display("FAIL ramp_b got n=%0d duty=%0d want n=1 duty=3", seq1.size(), duty_b);
        end
        checks++;
        if (duty_a !== 8'd3 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL ramp_a_end got %0d/%b want 3/0", duty_a, busy_a);
        end
    endtask

    task automatic test_clamp();
        bit to;
        int ex[$];
        do_load(8'd250);
        wait_idle(12000, to);
        checks++;
        if (to || duty_b !== 8'd250) begin
            errors++;
            $display("FAIL clamp_pre got %0d to=%0b want 250", duty_b, to);
        end
        seq0.delete();
        seq1.delete();
        do_load(8'd255);
        wait_idle(1000, to);
        checks++;
        if (to || seq1.size() != 1 || duty_b !== 8'd255) begin
            errors++;
            $display("FAIL clamp_up got n=%0d duty=%0d want n=1 duty=255", seq1.size(), duty_b);
        end
        checks++;
        if (seq0.size() != 5 || duty_a !== 8'd255) begin
            errors++;
            $display("FAIL clamp_up_a got n=%0d duty=%0d want n=5 duty=255", seq0.size(), duty_a);
        end
        seq0.delete();
        seq1.delete();
        do_load(8'd0);
        wait_idle(12000, to);
        for (int e = 255 - SB; e >= SB - 1; e -= SB) ex.push_back(e);
        ex.push_back(0);
        checks++;
        if (to || seq1.size() != ex.size()) begin
            errors++;
            $display("FAIL clamp_down_n got %0d want %0d", seq1.size(), ex.size());
        end else begin
            for (int k = 0; k < ex.size(); k++) begin
                checks++;
                if (seq1[k] !== 8'(ex[k])) begin
                    errors++;
                    $display("FAIL clamp_down[%0d] got %0d want %0d", k, seq1[k], ex[k]);
                end
            end
        end
        checks++;
        if (seq0.size() != 255 || duty_a !== 8'd0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL clamp_end got n=%0d a=%0d bb=%b want 255/0/0", seq0.size(), duty_a, busy_b);
        end
    endtask

    task automatic test_reversal();
        bit to;
        int n;
        logic [7:0] cur;
        do_load(8'd200);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(update_a === 1'b1 && duty_a == 8'd50) && n < 3000);
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL rev_reach50 got timeout want duty 50");
        end
        do_load(8'd20);
        for (int s = 0; s < 3; s++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (update_a !== 1'b1 && n < 200);
            checks++;
            if (n >= 200 || duty_a !== 8'(49 - s)) begin
                errors++;
                $display("FAIL rev_step%0d got %0d want %0d", s, duty_a, 49 - s);
            end
        end
        cur = duty_a;
        do_load(cur);
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rev_equal_busy got %b want 0", busy_a);
        end
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (update_a === 1'b1) n++;
        end
        checks++;
        if (n != 0 || duty_a !== cur) begin
            errors++;
            $display("FAIL rev_equal_upd got n=%0d duty=%0d want 0/%0d", n, duty_a, cur);
        end
        wait_idle(3000, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rev_timeout got timeout want idle");
        end
    endtask

    task automatic test_collision();
        int n;
        int ex;
        for (int it = 0; it < 8; it++) begin
            do_load(8'($urandom_range(0, 255)));
            n = 0;
            while (due[0] != ecnt + 1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 64) begin
                errors++;
                $display("FAIL coll_wait it%0d got timeout want step", it);
            end
            ex     = m_busy[0] ? toward(m_duty[0], m_tq[0], SA) : m_duty[0];
            target = 8'($urandom_range(0, 255));
            load   = 1'b1;
            @(negedge clk);
            load   = 1'b0;
            checks++;
            if (duty_a !== 8'(ex)) begin
                errors++;
                $display("FAIL coll_old_target it%0d got %0d want %0d", it, duty_a, ex);
            end
            repeat ($urandom_range(20, 80)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] last;
        do_load(duty_a ^ 8'h80);
        last = duty_a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (duty_a === last && n < 200);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL rmid_wait got timeout want step");
        end
        #2 nRst = 1'b0;
        #1;
        checks++;
        if ({duty_a, duty_b, update_a, update_b, busy_a, busy_b} !== 20'd0) begin
            errors++;
            $display("FAIL rmid_async got %h/%h u%b%b b%b%b want 0", duty_a, duty_b,
                     update_a, update_b, busy_a, busy_b);
        end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (update_a === 1'b1 || update_b === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL rmid_update got %0d want 0", n);
        end
        release_reset();
        do_load(8'd10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (update_a !== 1'b1 && n < 300);
        checks++;
        if (n >= 300 || rises != PA || duty_a !== 8'd1) begin
            errors++;
            $display("FAIL rmid_restart got rises=%0d duty=%0d want %0d/1", rises, duty_a, PA);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_reversal();
        test_collision();
        test_reset_mid();
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
